// File: rtl/uart_rcv_fifo_if.sv
// Host-side read bus of the UART receiver: FIFO head, status flags and pop/clear strobes.
// The receiver uses the slave modport; the host logic uses the master modport.
`timescale 1ns/1ps

interface uart_rcv_fifo_if #(
    parameter int unsigned FIFO_DEPTH_BITS = 4
) ();
    logic                     rd;
    logic                     ovr_clr;
    logic [7:0]               data;
    logic                     parity_valid;
    logic                     frame_err;
    logic                     empty;
    logic                     full;
    logic [FIFO_DEPTH_BITS:0] count;
    logic                     overrun;
    logic                     break_det;

    modport master (
        output rd, ovr_clr,
        input  data, parity_valid, frame_err, empty, full, count, overrun, break_det
    );

    modport slave (
        input  rd, ovr_clr,
        output data, parity_valid, frame_err, empty, full, count, overrun, break_det
    );
endinterface

// File: rtl/uart_rcv_fifo.sv
// Oversampling majority-vote UART receiver with runtime frame format, framing-error
// detection and a first-word-fall-through receive FIFO with sticky overrun.
// Optional feature macro: UART_RCV_FIFO_BREAK_DET_EN (line-break detection).
`timescale 1ns/1ps

module uart_rcv_fifo #(
    parameter int unsigned SAMPLE_WIDTH_BITS = 4,
    parameter int unsigned SAMPLE_BITS       = 5,
    parameter int unsigned FIFO_DEPTH_BITS   = 4
) (
    input  logic                         clk,
    input  logic                         Rst,
    input  logic [SAMPLE_WIDTH_BITS-1:0] sample_width,
    input  logic                         en_parity,
    input  logic                         odd_parity,
    input  logic [1:0]                   data_bits,
    input  logic                         two_stop,
    input  logic                         RXD,
    uart_rcv_fifo_if.slave               host
);

    localparam int unsigned SIDX_W = (SAMPLE_BITS > 1) ? $clog2(SAMPLE_BITS) : 1;
    localparam int unsigned VOTE_W = $clog2(SAMPLE_BITS + 1);
    localparam int unsigned DEPTH  = 1 << FIFO_DEPTH_BITS;
    localparam int unsigned CNT_W  = FIFO_DEPTH_BITS + 1;
    localparam int unsigned WORD_W = 10;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t                       state;
    logic                         rxd_meta, rxd_sync, rxd_prev;
    logic [1:0]                   sync_vld;
    logic [SAMPLE_WIDTH_BITS-1:0] samp_cnt;
    logic [SIDX_W-1:0]            samp_idx;
    logic [VOTE_W-1:0]            ones;
    logic [2:0]                   bit_idx;
    logic [7:0]                   shift;
    logic                         par_ok, ferr;
    logic                         en_par_l, odd_l, two_stop_l;
    logic [1:0]                   dbits_l;
    logic                         wait_high;
`ifdef UART_RCV_FIFO_BREAK_DET_EN
    logic                         par_bit, brk, break_q;
`endif

    logic                         tick_c, last_c, maj_c, fall_c, finish_c;
    logic                         ferr_fin_c, brk_fin_c, push_c;
    logic [VOTE_W-1:0]            ones_nxt_c;
    logic [2:0]                   last_idx_c;
    logic [WORD_W-1:0]            word_c;

    logic [WORD_W-1:0]            mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0]   wr_ptr, rd_ptr, rd_ptr_nxt_c;
    logic [CNT_W-1:0]             count_q, count_nxt_c;
    logic                         pop_c, full_now_c, acc_c, drop_c;
    logic [WORD_W-1:0]            head_c;
    logic [7:0]                   data_q;
    logic                         pv_q, fe_q, empty_q, full_q, overrun_q;

    // Two-flop synchroniser; sync_vld marks when rxd_sync reflects the real line after reset
    always_ff @(posedge clk) begin
        if (Rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
            sync_vld <= 2'b00;
        end else begin
            rxd_meta <= RXD;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    // Sample timing, majority vote and end-of-frame decode
    always_comb begin
        tick_c     = (samp_cnt == sample_width);
        last_c     = tick_c && (samp_idx == SIDX_W'(SAMPLE_BITS - 1));
        ones_nxt_c = ones + VOTE_W'(rxd_sync);
        maj_c      = (ones_nxt_c > VOTE_W'(SAMPLE_BITS / 2));
        fall_c     = rxd_prev & ~rxd_sync;
        last_idx_c = (dbits_l == 2'd0) ? 3'd7 : (3'd3 + {1'b0, dbits_l});
        finish_c   = last_c && (((state == STOP1) && !two_stop_l) || (state == STOP2));
        ferr_fin_c = (state == STOP1) ? ~maj_c : (ferr | ~maj_c);
`ifdef UART_RCV_FIFO_BREAK_DET_EN
        brk_fin_c  = (state == STOP1) ? ((shift == 8'h00) && !par_bit && !maj_c) : brk;
`else
        brk_fin_c  = 1'b0;
`endif
        push_c     = finish_c && !brk_fin_c;
        word_c     = {ferr_fin_c, par_ok, shift};
    end

    // Receive FSM with sample/vote counters and per-frame format latches
    always_ff @(posedge clk) begin
        if (Rst) begin
            state      <= IDLE;
            samp_cnt   <= '0;
            samp_idx   <= '0;
            ones       <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_ok     <= 1'b0;
            ferr       <= 1'b0;
            en_par_l   <= 1'b0;
            odd_l      <= 1'b0;
            two_stop_l <= 1'b0;
            dbits_l    <= 2'd0;
            wait_high  <= 1'b1;
`ifdef UART_RCV_FIFO_BREAK_DET_EN
            par_bit    <= 1'b0;
            brk        <= 1'b0;
            break_q    <= 1'b0;
`endif
        end else begin
            samp_cnt <= tick_c ? '0 : samp_cnt + SAMPLE_WIDTH_BITS'(1);
            if (tick_c) begin
                if (last_c) begin
                    samp_idx <= '0;
                    ones     <= '0;
                end else begin
                    samp_idx <= samp_idx + SIDX_W'(1);
                    ones     <= ones_nxt_c;
                end
            end
`ifdef UART_RCV_FIFO_BREAK_DET_EN
            break_q <= finish_c && brk_fin_c;
`endif
            case (state)
                IDLE: begin
                    // A start needs a genuine high-to-low transition seen after reset or a break
                    if (wait_high) begin
                        if (sync_vld[1] && rxd_sync) wait_high <= 1'b0;
                    end else if (fall_c) begin
                        samp_cnt   <= '0;
                        samp_idx   <= '0;
                        ones       <= '0;
                        bit_idx    <= '0;
                        shift      <= '0;
                        par_ok     <= 1'b1;
                        ferr       <= 1'b0;
                        en_par_l   <= en_parity;
                        odd_l      <= odd_parity;
                        two_stop_l <= two_stop;
                        dbits_l    <= data_bits;
`ifdef UART_RCV_FIFO_BREAK_DET_EN
                        par_bit    <= 1'b0;
                        brk        <= 1'b0;
`endif
                        state      <= START;
                    end
                end
                START: begin
                    if (last_c) state <= maj_c ? IDLE : DATA;
                end
                DATA: begin
                    if (last_c) begin
                        shift[bit_idx] <= maj_c;
                        if (bit_idx == last_idx_c) state <= en_par_l ? PARITY : STOP1;
                        else                       bit_idx <= bit_idx + 3'd1;
                    end
                end
                PARITY: begin
                    if (last_c) begin
                        par_ok <= (((^shift) ^ maj_c) == odd_l);
`ifdef UART_RCV_FIFO_BREAK_DET_EN
                        par_bit <= maj_c;
`endif
                        state  <= STOP1;
                    end
                end
                STOP1: begin
                    if (last_c) begin
                        ferr <= ~maj_c;
`ifdef UART_RCV_FIFO_BREAK_DET_EN
                        brk  <= brk_fin_c;
`endif
                        state <= two_stop_l ? STOP2 : IDLE;
                    end
                end
                STOP2: begin
                    if (last_c) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef UART_RCV_FIFO_BREAK_DET_EN
            if (finish_c && brk_fin_c) wait_high <= 1'b1;
`endif
        end
    end

    // FIFO bookkeeping: push accepted when not full or when a pop frees a slot the same cycle
    always_comb begin
        pop_c        = host.rd && (count_q != '0);
        full_now_c   = (count_q == CNT_W'(DEPTH));
        acc_c        = push_c && (!full_now_c || pop_c);
        drop_c       = push_c && full_now_c && !pop_c;
        rd_ptr_nxt_c = pop_c ? rd_ptr + FIFO_DEPTH_BITS'(1) : rd_ptr;
        count_nxt_c  = count_q + CNT_W'(acc_c) - CNT_W'(pop_c);
        if (count_nxt_c == '0)
            head_c = '0;
        else if (acc_c && (rd_ptr_nxt_c == wr_ptr))
            head_c = word_c;
        else
            head_c = mem[rd_ptr_nxt_c];
    end

    // Word storage
    always_ff @(posedge clk) begin
        if (acc_c) mem[wr_ptr] <= word_c;
    end

    // Pointers, count, registered head-of-FIFO outputs and sticky overrun
    always_ff @(posedge clk) begin
        if (Rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            data_q    <= 8'h00;
            pv_q      <= 1'b0;
            fe_q      <= 1'b0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (acc_c) wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
            rd_ptr  <= rd_ptr_nxt_c;
            count_q <= count_nxt_c;
            empty_q <= (count_nxt_c == '0);
            full_q  <= (count_nxt_c == CNT_W'(DEPTH));
            {fe_q, pv_q, data_q} <= head_c;
            if (drop_c)            overrun_q <= 1'b1;
            else if (host.ovr_clr) overrun_q <= 1'b0;
        end
    end

    assign host.data         = data_q;
    assign host.parity_valid = pv_q;
    assign host.frame_err    = fe_q;
    assign host.empty        = empty_q;
    assign host.full         = full_q;
    assign host.count        = count_q;
    assign host.overrun      = overrun_q;
`ifdef UART_RCV_FIFO_BREAK_DET_EN
    assign host.break_det    = break_q;
`else
    assign host.break_det    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rcv_fifo.sv
// Directed bench for uart_rcv_fifo: frame formats, errors, glitch rejection,
// FIFO fill/overrun, break handling and mid-frame reset.
`timescale 1ns/1ps

module tb_uart_rcv_fifo;

    localparam int unsigned SWB      = 5;
    localparam int unsigned SB       = 5;
    localparam int unsigned FDB      = 2;
    localparam int          BIT_CLKS = 90;

    logic           clk = 1'b0;
    logic           Rst;
    logic [SWB-1:0] sample_width;
    logic           en_parity, odd_parity, two_stop, RXD;
    logic [1:0]     data_bits;

    uart_rcv_fifo_if #(.FIFO_DEPTH_BITS(FDB)) bus ();

    uart_rcv_fifo #(
        .SAMPLE_WIDTH_BITS(SWB),
        .SAMPLE_BITS      (SB),
        .FIFO_DEPTH_BITS  (FDB)
    ) dut (
        .clk         (clk),
        .Rst         (Rst),
        .sample_width(sample_width),
        .en_parity   (en_parity),
        .odd_parity  (odd_parity),
        .data_bits   (data_bits),
        .two_stop    (two_stop),
        .RXD         (RXD),
        .host        (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] st, ex;

    function automatic logic [15:0] status();
        return {bus.data, bus.parity_valid, bus.frame_err, bus.empty, bus.full, bus.count, bus.overrun};
    endfunction

    function automatic logic [15:0] exp_st(input logic [7:0] d, input logic pv, input logic fe,
                                           input logic em, input logic fu, input logic [2:0] cnt,
                                           input logic ov);
        return {d, pv, fe, em, fu, cnt, ov};
    endfunction

    // Serial frame; returns on the negedge just before the push clock edge
    task automatic send_frame(input logic [7:0] d, input int nd, input bit has_par,
                              input bit par_bit, input int nstop, input bit stop_val);
        RXD = 1'b1;
        repeat (20) @(negedge clk);
        RXD = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < nd; i++) begin
            RXD = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (has_par) begin
            RXD = par_bit;
            repeat (BIT_CLKS) @(negedge clk);
        end
        for (int i = 0; i < nstop; i++) begin
            RXD = stop_val;
            repeat (BIT_CLKS) @(negedge clk);
        end
        RXD = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pop();
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
    endtask

    task automatic set_8n1();
        en_parity = 1'b0; odd_parity = 1'b0; data_bits = 2'd0; two_stop = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) @(negedge clk);
        Rst = 1'b0;
        @(negedge clk);
        st = status(); ex = exp_st(8'h00, 0, 0, 1, 0, 3'd0, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL reset_state: got %h expected %h", st, ex); end
        n_checks++;
        if (bus.break_det !== 1'b0) begin n_fail++; $display("FAIL reset_break: got %b expected 0", bus.break_det); end
    endtask

    task automatic test_8n1();
        set_8n1();
        send_frame(8'hA5, 8, 0, 0, 1, 1);
        st = status(); ex = exp_st(8'h00, 0, 0, 1, 0, 3'd0, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL 8n1_before_push: got %h expected %h", st, ex); end
        @(negedge clk);
        st = status(); ex = exp_st(8'hA5, 1, 0, 0, 0, 3'd1, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL 8n1_word: got %h expected %h", st, ex); end
        pop();
        st = status(); ex = exp_st(8'h00, 0, 0, 1, 0, 3'd0, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL 8n1_pop: got %h expected %h", st, ex); end
    endtask

    task automatic test_7o2();
        en_parity = 1'b1; odd_parity = 1'b1; data_bits = 2'd3; two_stop = 1'b1;
        send_frame(8'h53, 7, 1, 1, 2, 1);
        @(negedge clk);
        st = status(); ex = exp_st(8'h53, 1, 0, 0, 0, 3'd1, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL 7o2_first: got %h expected %h", st, ex); end
        send_frame(8'h2A, 7, 1, 1, 2, 1);
        @(negedge clk);
        st = status(); ex = exp_st(8'h53, 1, 0, 0, 0, 3'd2, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL 7o2_two_words: got %h expected %h", st, ex); end
        pop();
        st = status(); ex = exp_st(8'h2A, 0, 0, 0, 0, 3'd1, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL 7o2_bad_parity: got %h expected %h", st, ex); end
        pop();
        st = status(); ex = exp_st(8'h00, 0, 0, 1, 0, 3'd0, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL 7o2_drain: got %h expected %h", st, ex); end
    endtask

    task automatic test_5e1_frame_err();
        en_parity = 1'b1; odd_parity = 1'b0; data_bits = 2'd1; two_stop = 1'b0;
        send_frame(8'hF6, 5, 1, 1, 1, 0);
        @(negedge clk);
        st = status(); ex = exp_st(8'h16, 1, 1, 0, 0, 3'd1, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL 5e1_frame_err: got %h expected %h", st, ex); end
        pop();
    endtask

    task automatic test_glitch();
        set_8n1();
        RXD = 1'b0;
        repeat (36) @(negedge clk);
        RXD = 1'b1;
        repeat (1000) @(negedge clk);
        st = status(); ex = exp_st(8'h00, 0, 0, 1, 0, 3'd0, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL glitch_no_push: got %h expected %h", st, ex); end
        send_frame(8'h3C, 8, 0, 0, 1, 1);
        @(negedge clk);
        st = status(); ex = exp_st(8'h3C, 1, 0, 0, 0, 3'd1, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL glitch_recover: got %h expected %h", st, ex); end
        pop();
    endtask

    task automatic test_overrun();
        logic [7:0] rest [3];
        rest[0] = 8'h33; rest[1] = 8'h44; rest[2] = 8'h66;
        set_8n1();
        send_frame(8'h11, 8, 0, 0, 1, 1); @(negedge clk);
        send_frame(8'h22, 8, 0, 0, 1, 1); @(negedge clk);
        send_frame(8'h33, 8, 0, 0, 1, 1); @(negedge clk);
        send_frame(8'h44, 8, 0, 0, 1, 1); @(negedge clk);
        st = status(); ex = exp_st(8'h11, 1, 0, 0, 1, 3'd4, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL fifo_full: got %h expected %h", st, ex); end
        send_frame(8'h55, 8, 0, 0, 1, 1); @(negedge clk);
        st = status(); ex = exp_st(8'h11, 1, 0, 0, 1, 3'd4, 1); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL overrun_set: got %h expected %h", st, ex); end
        bus.ovr_clr = 1'b1;
        @(negedge clk);
        bus.ovr_clr = 1'b0;
        st = status(); ex = exp_st(8'h11, 1, 0, 0, 1, 3'd4, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL overrun_clear: got %h expected %h", st, ex); end
        send_frame(8'h66, 8, 0, 0, 1, 1);
        pop();
        st = status(); ex = exp_st(8'h22, 1, 0, 0, 1, 3'd4, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL full_push_with_rd: got %h expected %h", st, ex); end
        for (int i = 0; i < 3; i++) begin
            pop();
            st = status(); ex = exp_st(rest[i], 1, 0, 0, 0, 3'(3 - i), 0); n_checks++;
            if (st !== ex) begin n_fail++; $display("FAIL fifo_order_%0d: got %h expected %h", i, st, ex); end
        end
        pop();
        st = status(); ex = exp_st(8'h00, 0, 0, 1, 0, 3'd0, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL fifo_drain: got %h expected %h", st, ex); end
        pop();
        st = status(); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL empty_rd_ignored: got %h expected %h", st, ex); end
    endtask

    task automatic test_break();
        int pulses;
        pulses = 0;
        set_8n1();
        RXD = 1'b1;
        repeat (20) @(negedge clk);
        RXD = 1'b0;
        for (int i = 0; i < 1300; i++) begin
            if (i == 12 * BIT_CLKS) RXD = 1'b1;
            @(negedge clk);
            if (bus.break_det === 1'b1) pulses++;
        end
        st = status();
`ifdef UART_RCV_FIFO_BREAK_DET_EN
        ex = exp_st(8'h00, 0, 0, 1, 0, 3'd0, 0); n_checks++;
        if (pulses !== 1) begin n_fail++; $display("FAIL break_pulses: got %0d expected 1", pulses); end
`else
        ex = exp_st(8'h00, 1, 1, 0, 0, 3'd1, 0); n_checks++;
        if (pulses !== 0) begin n_fail++; $display("FAIL break_pulses: got %0d expected 0", pulses); end
`endif
        n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL break_fifo: got %h expected %h", st, ex); end
        if (bus.empty === 1'b0) pop();
        send_frame(8'h81, 8, 0, 0, 1, 1);
        @(negedge clk);
        st = status(); ex = exp_st(8'h81, 1, 0, 0, 0, 3'd1, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL after_break: got %h expected %h", st, ex); end
        pop();
    endtask

    task automatic test_reset_mid_frame();
        set_8n1();
        send_frame(8'h5A, 8, 0, 0, 1, 1);
        @(negedge clk);
        st = status(); ex = exp_st(8'h5A, 1, 0, 0, 0, 3'd1, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL pre_reset_word: got %h expected %h", st, ex); end
        RXD = 1'b0;
        repeat (300) @(negedge clk);
        Rst = 1'b1;
        repeat (3) @(negedge clk);
        Rst = 1'b0;
        @(negedge clk);
        st = status(); ex = exp_st(8'h00, 0, 0, 1, 0, 3'd0, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL mid_reset_state: got %h expected %h", st, ex); end
        n_checks++;
        if (bus.break_det !== 1'b0) begin n_fail++; $display("FAIL mid_reset_break: got %b expected 0", bus.break_det); end
        repeat (1000) @(negedge clk);
        st = status(); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL low_through_reset: got %h expected %h", st, ex); end
        send_frame(8'hC3, 8, 0, 0, 1, 1);
        @(negedge clk);
        st = status(); ex = exp_st(8'hC3, 1, 0, 0, 0, 3'd1, 0); n_checks++;
        if (st !== ex) begin n_fail++; $display("FAIL post_reset_frame: got %h expected %h", st, ex); end
    endtask

    initial begin
        Rst          = 1'b1;
        RXD          = 1'b1;
        sample_width = SWB'(17);
        en_parity    = 1'b0;
        odd_parity   = 1'b0;
        data_bits    = 2'd0;
        two_stop     = 1'b0;
        bus.rd       = 1'b0;
        bus.ovr_clr  = 1'b0;
        test_reset();
        test_8n1();
        test_7o2();
        test_5e1_frame_err();
        test_glitch();
        test_overrun();
        test_break();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rcv_fifo.md
# uart_rcv_fifo

Parametrised successor to the UART receiver: an oversampling, majority-voting serial receiver with runtime frame format and an optional second stop bit. It adds framing-error detection and a first-word-fall-through receive FIFO with overrun flagging, so software reads can lag the line. It sits between the RXD pin and the host-side bus logic, on the same clock as the matching transmitter.

## Interface
Parameters:
- SAMPLE_WIDTH_BITS, 4: width of `sample_width`.
- SAMPLE_BITS, 5: samples per bit; odd, at least 3.
- FIFO_DEPTH_BITS, 4: FIFO holds 2^FIFO_DEPTH_BITS words.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- Rst  in  1  synchronous, active-high reset.
- sample_width  in  SAMPLE_WIDTH_BITS  clock cycles per sample minus 1.
- en_parity  in  1  parity bit present.
- odd_parity  in  1  1 = odd parity, 0 = even parity.
- data_bits  in  2  0 = 8 bits, 1 = 5 bits, 2 = 6 bits, 3 = 7 bits.
- two_stop  in  1  expect two stop bits.
- RXD  in  1  serial input; asynchronous; idles high.
- rd  in  1  pop strobe; ignored when `empty` is high.
- data  out  8  head-of-FIFO data, LSB-aligned, unused MSBs zero; reset value 0.
- parity_valid  out  1  head word parity is correct; always 1 when parity is off; reset value 0.
- frame_err  out  1  head word had a bad stop bit; reset value 0.
- empty  out  1  FIFO empty; reset value 1.
- full  out  1  FIFO full; reset value 0.
- count  out  FIFO_DEPTH_BITS+1  number of words in the FIFO; reset value 0.
- overrun  out  1  sticky flag: a word was dropped; reset value 0.
- ovr_clr  in  1  clears `overrun`.
- break_det  out  1  one-cycle break pulse; reset value 0; tied to 0 when the macro is absent.

## Operation
- RXD passes through a 2-flop synchroniser; both flops reset to 1.
- A sample counter runs 0..sample_width. A sample tick fires when the counter equals sample_width.
- The FSM has states IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: a falling edge on synchronised RXD does the following:
  - clears the sample counter and the vote counter;
  - latches en_parity, odd_parity, data_bits and two_stop for the whole frame;
  - moves to START.
- Each bit is SAMPLE_BITS ticks long. The bit value is the majority of its samples, decided on the last tick.
- START: a majority of 1 is a false start and returns to IDLE with no push. A majority of 0 goes to DATA.
- DATA: bits are shifted LSB first; 5, 6, 7 or 8 bits are received per the latched data_bits. Then go to PARITY if parity is enabled, else STOP1.
- PARITY: parity_valid is set when (XOR of data bits) XOR (parity bit) equals the latched odd_parity.
- STOP1: frame_err is set if the majority is 0. Go to STOP2 if two_stop is set, else finish.
- STOP2: frame_err is also set if this majority is 0.
- Finish: push {frame_err, parity_valid, data} into the FIFO and return to IDLE in the same cycle.
- If the FIFO is full and rd is not asserted in the push cycle, the word is dropped and overrun is set.
- If the FIFO is full and rd is asserted in the same cycle, the push is accepted, count is unchanged and overrun is not set.
- rd on an empty FIFO is ignored; count does not underflow.
- FIFO pointers wrap modulo 2^FIFO_DEPTH_BITS.
- Reset mid-frame: FSM goes to IDLE, FIFO empties, flags clear. A line held low through reset is not taken as a start, because a falling edge is required.
- When ovr_clr and a new overrun occur in the same cycle, the set wins.

## Timing
- The falling edge enters the FSM 2 cycles after it appears on RXD (synchroniser delay).
- Each bit lasts SAMPLE_BITS*(sample_width+1) clocks.
- Push happens on the clock of the last stop-bit tick. The word appears on data, empty falls and count increments on the following clock.
- FIFO is first-word-fall-through: after rd, the next word appears on the outputs on the following clock.
- break_det is asserted for exactly one clock, in the cycle the push would have happened.

## Configuration
- Macro: UART_RCV_FIFO_BREAK_DET_EN.
- Defined: a frame with all data bits 0, the parity bit (if enabled) 0 and STOP1 0 is a break.
  - It pulses break_det and is not pushed.
  - The FSM then waits in IDLE for RXD high before accepting a new falling edge.
- Undefined: break_det is constant 0. Such a frame is pushed as data 0 with frame_err=1.

## Test plan
- 8N1, sample_width=17, SAMPLE_BITS=5; send 0xA5 -> data=0xA5, parity_valid=1, frame_err=0, count=1 one clock after the stop tick.
- 7O2; send 0x53 with correct parity, then a second byte with the parity bit flipped -> words 0x53 (parity_valid=1), then parity_valid=0 on the second word.
- 5E1; send a frame with the stop bit forced low -> frame_err=1, data=bits[4:0], bits[7:5]=0.
- Glitch: RXD low for 2 samples only -> false start, no push, FSM back in IDLE.
- FIFO_DEPTH_BITS=2: send 5 bytes with no reads -> full=1, count=4, overrun=1, the first 4 bytes read back in order; pulse ovr_clr -> overrun=0.
- Macro defined: hold RXD low for 12 bit times -> a single break_det pulse, count unchanged. Assert Rst mid-frame -> empty=1 and all outputs at their reset values.
